uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_idle_timer.sv | 39 +++
 rtl/uart_cmd_parser.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Holds the parser state encoding, error codes and default header bytes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hAA;

  // Frame checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry on the cycle the count sits at TIMEOUT_CYCLES-1.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at LAST so a stalled enable can never wrap back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q < LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses 8-byte register-write frames (HDR0 HDR1 ADDR D3 D2 D1 D0 CSUM) from a
// UART byte stream and issues a single-cycle register write or error strobe.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0] HDR0           = DEF_HDR0,
  parameter logic [7:0] HDR1           = DEF_HDR1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  state_e      state_q;
  logic [7:0]  addr_sh_q;
  logic [31:0] data_sh_q;
  logic [7:0]  sum_q;
  logic [1:0]  byte_cnt_q;
  logic        reg_wr_en_q;
  logic        frame_err_q;
  logic [1:0]  err_code_q;
  logic [7:0]  reg_addr_q;
  logic [31:0] reg_wdata_q;

  logic        tmr_clear;
  logic        tmr_enable;
  logic        tmr_expired;

  assign tmr_clear  = rx_done || (state_q == ST_IDLE);
  assign tmr_enable = (state_q != ST_IDLE);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // A received byte always wins over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      sum_q       <= '0;
      byte_cnt_q  <= '0;
      reg_wr_en_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      reg_wr_en_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_done) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == HDR0) state_q <= ST_HDR;
          end
          ST_HDR: begin
            if (rx_data == HDR1)      state_q <= ST_ADDR;
            else if (rx_data == HDR0) state_q <= ST_HDR;
            else                      state_q <= ST_IDLE;
          end
          ST_ADDR: begin
            addr_sh_q  <= rx_data;
            sum_q      <= rx_data;
            byte_cnt_q <= 2'd0;
            state_q    <= ST_DATA;
          end
          ST_DATA: begin
            data_sh_q  <= {data_sh_q[23:0], rx_data};
            sum_q      <= sum8(sum_q, rx_data);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_q <= ST_CSUM;
          end
          ST_CSUM: begin
            if (rx_data == sum_q) begin
              reg_wr_en_q <= 1'b1;
              reg_addr_q  <= addr_sh_q;
              reg_wdata_q <= data_sh_q;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmr_expired) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end
    end
  end

  assign reg_wr_en = reg_wr_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
